dffrn_exerciser: RTL and testbench

- Synthesizable stimulus generator and checker for one external dffrn_1-style flop: posedge-CLKN capture, active-low async RN, Q/QN outputs.
- Drives D, RN and CLKN from an on-chip LFSR sequence, samples Q/QN, and compares them against an internal golden model.
- Reports pass/fail and an error count.
- Sits in the library silicon-validation harness on the initiator side; the cell under test is the responder.

---
 rtl/dffrn_exerciser_pkg.sv | 23 ++
 rtl/dffrn_exerciser_lfsr.sv | 36 +++
 rtl/dffrn_exerciser.sv | 177 +++++++++++++++++
 tb/tb_dffrn_exerciser.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dffrn_exerciser_pkg.sv
// Shared types and constants for the dffrn_1 exerciser.
// Optional mid-run reset windows are enabled by DFFRN_EXERCISER_MIDRST_EN.
package dffrn_exerciser_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_CHK = 3'd1,
    SETUP   = 3'd2,
    HIGH    = 3'd3,
    FALL    = 3'd4,
    MID_RST = 3'd5,
    DONE_ST = 3'd6
  } state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Fibonacci step: taps 16,14,13,11, feedback shifted in at bit 0.
  function automatic logic [15:0] lfsr_advance(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dffrn_exerciser_lfsr.sv
// 16-bit vector LFSR with load and step; a zero seed is replaced by the default.
// next_o is the value the register takes on the coming edge.
module dffrn_exerciser_lfsr
  import dffrn_exerciser_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  output logic [15:0] next_o
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  logic [15:0] lfsr_q;

  always_comb begin
    next_o = lfsr_q;
    if (load_i) begin
      next_o = SEED_EFF;
    end else if (step_i) begin
      next_o = lfsr_advance(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= next_o;
    end
  end

endmodule

// File: rtl/dffrn_exerciser.sv
// Stimulus generator and checker for one external dffrn_1 flop (posedge CLKN, active-low RN).
// Define DFFRN_EXERCISER_MIDRST_EN to insert a reset window after every 16th vector.
module dffrn_exerciser
  import dffrn_exerciser_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned CLK_DIV     = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             d_o,
  output logic             rn_o,
  output logic             clkn_o,
  input  logic             q_i,
  input  logic             qn_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [15:0]      vec_cnt_o
);

  state_e            state_q, state_d;
  logic [7:0]        phase_q, phase_d;
  logic              d_q, d_d;
  logic              rn_q, rn_d;
  logic              clkn_q, clkn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [15:0]       vec_q, vec_d;

  logic              phase_last;
  logic              lfsr_load;
  logic              lfsr_step;
  logic [15:0]       lfsr_next;
  logic [15:0]       vec_inc;
  logic              sample_en;
  logic              exp_bit;

  assign phase_last = (phase_q == 8'(CLK_DIV - 1));
  assign lfsr_load  = (state_q == IDLE) && start_i;
  assign lfsr_step  = (state_q == FALL) && phase_last;
  assign vec_inc    = vec_q + 16'd1;

  dffrn_exerciser_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .next_o (lfsr_next)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    vec_d     = vec_q;
    sample_en = 1'b0;
    exp_bit   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RST_CHK;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          vec_d   = '0;
        end
      end
      RST_CHK: begin
        sample_en = phase_last;
        if (phase_last) state_d = SETUP;
      end
      SETUP: begin
        if (phase_last) state_d = HIGH;
      end
      HIGH: begin
        sample_en = phase_last;
        exp_bit   = d_q;
        if (phase_last) state_d = FALL;
      end
      FALL: begin
        if (phase_last) begin
          vec_d = vec_inc;
          if (vec_inc == 16'(NUM_VECTORS)) begin
            state_d = DONE_ST;
          end else begin
`ifdef DFFRN_EXERCISER_MIDRST_EN
            state_d = (vec_inc[3:0] == 4'd0) ? MID_RST : SETUP;
`else
            state_d = SETUP;
`endif
          end
        end
      end
`ifdef DFFRN_EXERCISER_MIDRST_EN
      MID_RST: begin
        sample_en = phase_last;
        if (phase_last) state_d = SETUP;
      end
`endif
      DONE_ST: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
      end
      default: state_d = IDLE;
    endcase

    // Reset windows expect Q=0 (exp_bit stays 0); captures expect the driven D.
    if (sample_en && ((q_i != exp_bit) || (qn_i != ~exp_bit)) && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  // Pin outputs are registered decodes of the next state so they align with state_q.
  always_comb begin
    phase_d = 8'd0;
    if ((state_d == state_q) && (state_q != IDLE)) begin
      phase_d = phase_q + 8'd1;
    end
    d_d    = d_q;
    if ((state_d == SETUP) && (state_q != SETUP)) begin
      d_d = lfsr_next[0];
    end
    rn_d   = (state_d == SETUP) || (state_d == HIGH) || (state_d == FALL) || (state_d == DONE_ST);
    clkn_d = (state_d == HIGH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= 8'd0;
      d_q     <= 1'b0;
      rn_q    <= 1'b0;
      clkn_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      d_q     <= d_d;
      rn_q    <= rn_d;
      clkn_q  <= clkn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
    end
  end

  assign d_o       = d_q;
  assign rn_o      = rn_q;
  assign clkn_o    = clkn_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_q;
  assign vec_cnt_o = vec_q;

endmodule

// File: tb/tb_dffrn_exerciser.sv
// Self-checking bench: behavioural dffrn_1 with selectable faults, LFSR-derived expectations.
// Honours DFFRN_EXERCISER_MIDRST_EN for expected run length and error counts.
module tb_dffrn_exerciser;

  localparam int          N    = 256;
  localparam int          CD   = 4;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef DFFRN_EXERCISER_MIDRST_EN
  localparam int NMID = (N - 1) / 16;
`else
  localparam int NMID = 0;
`endif
  localparam int RUN_CYC = 1 + CD * (1 + 3 * N + NMID);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        d_o, rn_o, clkn_o, busy_o, done_o, pass_o;
  logic        q_i, qn_i;
  logic [15:0] err_cnt_o, vec_cnt_o;

  int   checks = 0;
  int   fails  = 0;
  int   mode   = 0;   // 0 good, 1 Q inverted, 2 QN stuck 0, 3 random Q flips
  int   flips  = 0;
  int   mid_seen = 0;
  int   d_age = 0;
  int   rn_age = 0;
  int   zeros = 0;
  logic prev_d = 1'b0;
  logic prev_rn = 1'b0;
  logic cut_q = 1'b0;
  bit   flip_bit;
  bit   vec_bits [N];

  dffrn_exerciser #(
    .NUM_VECTORS (N),
    .CLK_DIV     (CD),
    .LFSR_SEED   (SEED),
    .ERR_W       (16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .d_o       (d_o),
    .rn_o      (rn_o),
    .clkn_o    (clkn_o),
    .q_i       (q_i),
    .qn_i      (qn_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .pass_o    (pass_o),
    .err_cnt_o (err_cnt_o),
    .vec_cnt_o (vec_cnt_o)
  );

  always #5 clk = ~clk;

  // Cell under test with fault injection on its pins.
  always @(posedge clkn_o or negedge rn_o) begin
    if (!rn_o) begin
      cut_q <= 1'b0;
    end else begin
      flip_bit = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (flip_bit) flips++;
      cut_q <= d_o ^ flip_bit;
    end
  end
  assign q_i  = (mode == 1) ? ~cut_q : cut_q;
  assign qn_i = (mode == 2) ? 1'b0 : ~cut_q;

  always @(negedge clk) begin
    if (d_o !== prev_d) d_age = 1; else d_age++;
    if (rn_o === 1'b1) rn_age++; else rn_age = 0;
    if (busy_o && prev_rn && !rn_o) mid_seen++;
    prev_d  = d_o;
    prev_rn = rn_o;
  end

  // Every capture edge: data follows the LFSR sequence and meets setup/recovery.
  always @(posedge clkn_o) begin
    if (busy_o === 1'b1) begin
      checks++;
      if (int'(vec_cnt_o) >= N || d_o !== vec_bits[int'(vec_cnt_o)]) begin
        fails++;
        $display("FAIL d_seq vec=%0d got=%b", vec_cnt_o, d_o);
      end
      checks++;
      if (d_age < CD) begin
        fails++;
        $display("FAIL setup vec=%0d got=%0d need>=%0d", vec_cnt_o, d_age, CD);
      end
      checks++;
      if (rn_age < CD) begin
        fails++;
        $display("FAIL recovery vec=%0d got=%0d need>=%0d", vec_cnt_o, rn_age, CD);
      end
    end
  end

  task automatic build_model();
    logic [15:0] x;
    x = SEED;
    zeros = 0;
    for (int k = 0; k < N; k++) begin
      vec_bits[k] = x[0];
      if (x[0] == 1'b0) zeros++;
      x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    end
  endtask

  // Pulse START, optionally re-pulse it mid-run, and count cycles until DONE.
  task automatic do_run(input bit extra, output int cycles, output bit timeout);
    int p0, p1, p2;
    p0 = $urandom_range(1, RUN_CYC - 2);
    p1 = $urandom_range(1, RUN_CYC - 2);
    p2 = $urandom_range(1, 20);
    mid_seen = 0;
    flips = 0;
    cycles = 0;
    timeout = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cycles++;
      if (done_o) break;
      if (cycles > 20000) begin
        timeout = 1'b1;
        break;
      end
      start = extra && (cycles == p0 || cycles == p1 || cycles == p2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (d_o !== 1'b0)      begin fails++; $display("FAIL rst_d got=%b need=0", d_o); end
    checks++; if (rn_o !== 1'b0)     begin fails++; $display("FAIL rst_rn got=%b need=0", rn_o); end
    checks++; if (clkn_o !== 1'b0)   begin fails++; $display("FAIL rst_clkn got=%b need=0", clkn_o); end
    checks++; if (busy_o !== 1'b0)   begin fails++; $display("FAIL rst_busy got=%b need=0", busy_o); end
    checks++; if (done_o !== 1'b0)   begin fails++; $display("FAIL rst_done got=%b need=0", done_o); end
    checks++; if (pass_o !== 1'b0)   begin fails++; $display("FAIL rst_pass got=%b need=0", pass_o); end
    checks++; if (err_cnt_o !== 16'd0) begin fails++; $display("FAIL rst_err got=%0d need=0", err_cnt_o); end
    checks++; if (vec_cnt_o !== 16'd0) begin fails++; $display("FAIL rst_vec got=%0d need=0", vec_cnt_o); end
    rst = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_clean_run();
    int cyc; bit to;
    mode = 0;
    do_run(1'b0, cyc, to);
    checks++; if (to || cyc != RUN_CYC) begin fails++; $display("FAIL clean_len got=%0d need=%0d", cyc, RUN_CYC); end
    checks++; if (pass_o !== 1'b1) begin fails++; $display("FAIL clean_pass got=%b need=1", pass_o); end
    checks++; if (err_cnt_o !== 16'd0) begin fails++; $display("FAIL clean_err got=%0d need=0", err_cnt_o); end
    checks++; if (vec_cnt_o !== 16'(N)) begin fails++; $display("FAIL clean_vec got=%0d need=%0d", vec_cnt_o, N); end
    checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL clean_busy got=%b need=0", busy_o); end
    checks++; if (mid_seen != NMID) begin fails++; $display("FAIL clean_midrst got=%0d need=%0d", mid_seen, NMID); end
    $display("clean run: cycles=%0d err=%0d vec=%0d pass=%b", cyc, err_cnt_o, vec_cnt_o, pass_o);
  endtask

  task automatic test_invert_q();
    int cyc; bit to; int exp_err;
    mode = 1;
    exp_err = N + 1 + NMID;
    do_run(1'b0, cyc, to);
    checks++; if (to || cyc != RUN_CYC) begin fails++; $display("FAIL invq_len got=%0d need=%0d", cyc, RUN_CYC); end
    checks++; if (err_cnt_o !== 16'(exp_err)) begin fails++; $display("FAIL invq_err got=%0d need=%0d", err_cnt_o, exp_err); end
    checks++; if (pass_o !== 1'b0) begin fails++; $display("FAIL invq_pass got=%b need=0", pass_o); end
    $display("inverted Q run: err=%0d pass=%b", err_cnt_o, pass_o);
  endtask

  task automatic test_qn_stuck();
    int cyc; bit to; int exp_err;
    mode = 2;
    exp_err = zeros + 1 + NMID;
    do_run(1'b0, cyc, to);
    checks++; if (to) begin fails++; $display("FAIL qn0_timeout got=%0d need=%0d", cyc, RUN_CYC); end
    checks++; if (err_cnt_o !== 16'(exp_err)) begin fails++; $display("FAIL qn0_err got=%0d need=%0d", err_cnt_o, exp_err); end
    checks++; if (pass_o !== 1'b0) begin fails++; $display("FAIL qn0_pass got=%b need=0", pass_o); end
    $display("QN stuck-0 run: err=%0d zeros=%0d", err_cnt_o, zeros);
  endtask

  task automatic test_random_flips();
    int cyc; bit to;
    mode = 3;
    do_run(1'b0, cyc, to);
    checks++; if (to) begin fails++; $display("FAIL flip_timeout got=%0d need=%0d", cyc, RUN_CYC); end
    checks++; if (err_cnt_o !== 16'(flips)) begin fails++; $display("FAIL flip_err got=%0d need=%0d", err_cnt_o, flips); end
    checks++; if (pass_o !== (flips == 0)) begin fails++; $display("FAIL flip_pass got=%b need=%b", pass_o, flips == 0); end
    $display("random flip run: flips=%0d err=%0d", flips, err_cnt_o);
  endtask

  task automatic test_start_ignored();
    int cyc; bit to;
    mode = 0;
    do_run(1'b1, cyc, to);
    checks++; if (to || cyc != RUN_CYC) begin fails++; $display("FAIL extra_start_len got=%0d need=%0d", cyc, RUN_CYC); end
    checks++; if (vec_cnt_o !== 16'(N)) begin fails++; $display("FAIL extra_start_vec got=%0d need=%0d", vec_cnt_o, N); end
    checks++; if (pass_o !== 1'b1) begin fails++; $display("FAIL extra_start_pass got=%b need=1", pass_o); end
    $display("extra START run: cycles=%0d vec=%0d", cyc, vec_cnt_o);
  endtask

  task automatic test_midrun_reset();
    int n; int cyc; bit to;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (vec_cnt_o != 16'd100 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 20000) begin fails++; $display("FAIL midrun_wait got=%0d need=100", vec_cnt_o); end
    repeat ($urandom_range(0, 7)) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0)
      begin fails++; $display("FAIL midrun_flags got=%b%b%b need=000", busy_o, done_o, pass_o); end
    checks++; if (rn_o !== 1'b0 || clkn_o !== 1'b0 || d_o !== 1'b0)
      begin fails++; $display("FAIL midrun_pins got=%b%b%b need=000", rn_o, clkn_o, d_o); end
    checks++; if (vec_cnt_o !== 16'd0 || err_cnt_o !== 16'd0)
      begin fails++; $display("FAIL midrun_cnt got=%0d/%0d need=0/0", vec_cnt_o, err_cnt_o); end
    @(negedge clk);
    rst = 1'b0;
    do_run(1'b0, cyc, to);
    checks++; if (to || cyc != RUN_CYC) begin fails++; $display("FAIL rerun_len got=%0d need=%0d", cyc, RUN_CYC); end
    checks++; if (pass_o !== 1'b1 || err_cnt_o !== 16'd0) begin fails++; $display("FAIL rerun_pass got=%b/%0d need=1/0", pass_o, err_cnt_o); end
    $display("mid-run reset then rerun: cycles=%0d pass=%b", cyc, pass_o);
  endtask

  initial begin
    build_model();
    test_reset();
    test_clean_run();
    test_invert_q();
    test_qn_stuck();
    test_random_flips();
    test_start_ignored();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
